// File: rtl/control_sequencer_pkg.sv
// Shared constants and types for the hardwired Mini SRC control unit:
// opcodes, ALU functions, bus source selects, sequencer states and instruction classes.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_ROR  = 4'b0100;
  localparam logic [3:0] ALU_ROL  = 4'b0101;
  localparam logic [3:0] ALU_SHR  = 4'b0110;
  localparam logic [3:0] ALU_SHL  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_DIV  = 4'b1001;
  localparam logic [3:0] ALU_NEG  = 4'b1010;
  localparam logic [3:0] ALU_NOT  = 4'b1011;
  localparam logic [3:0] ALU_SHRA = 4'b1100;

  localparam logic [4:0] SEL_HI  = 5'b10000;
  localparam logic [4:0] SEL_LO  = 5'b10001;
  localparam logic [4:0] SEL_ZHI = 5'b10010;
  localparam logic [4:0] SEL_ZLO = 5'b10011;
  localparam logic [4:0] SEL_PC  = 5'b10100;
  localparam logic [4:0] SEL_MDR = 5'b10101;

  typedef enum logic [2:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_RRR, CL_UNARY, CL_MULDIV, CL_NOP, CL_HALT, CL_BAD
  } iclass_e;

endpackage

// File: rtl/control_sequencer_if.sv
// Decode channel between the sequencer (master: supplies opcode) and
// the opcode decoder (slave: returns instruction class and ALU function).
interface control_sequencer_if import cpu_ctrl_pkg::*; #(
  parameter int OPW = 5
) ();
  logic [OPW-1:0] opcode;
  iclass_e        iclass;
  logic [3:0]     alu_op;

  modport master (output opcode, input iclass, alu_op);
  modport slave  (input opcode, output iclass, alu_op);
endinterface

// File: rtl/control_sequencer_decode.sv
// Combinational opcode decoder: maps the IR opcode field to an instruction
// class and the ALU function used in that class's ALU step.
module control_decode import cpu_ctrl_pkg::*; (
  control_sequencer_if.slave dec
);

  always_comb begin
    dec.iclass = CL_BAD;
    dec.alu_op = ALU_ADD;
    case (dec.opcode)
      OP_ADD:  begin dec.iclass = CL_RRR;    dec.alu_op = ALU_ADD;  end
      OP_SUB:  begin dec.iclass = CL_RRR;    dec.alu_op = ALU_SUB;  end
      OP_AND:  begin dec.iclass = CL_RRR;    dec.alu_op = ALU_AND;  end
      OP_OR:   begin dec.iclass = CL_RRR;    dec.alu_op = ALU_OR;   end
      OP_ROR:  begin dec.iclass = CL_RRR;    dec.alu_op = ALU_ROR;  end
      OP_ROL:  begin dec.iclass = CL_RRR;    dec.alu_op = ALU_ROL;  end
      OP_SHR:  begin dec.iclass = CL_RRR;    dec.alu_op = ALU_SHR;  end
      OP_SHRA: begin dec.iclass = CL_RRR;    dec.alu_op = ALU_SHRA; end
      OP_SHL:  begin dec.iclass = CL_RRR;    dec.alu_op = ALU_SHL;  end
      OP_MUL:  begin dec.iclass = CL_MULDIV; dec.alu_op = ALU_MUL;  end
      OP_DIV:  begin dec.iclass = CL_MULDIV; dec.alu_op = ALU_DIV;  end
      OP_NEG:  begin dec.iclass = CL_UNARY;  dec.alu_op = ALU_NEG;  end
      OP_NOT:  begin dec.iclass = CL_UNARY;  dec.alu_op = ALU_NOT;  end
      OP_NOP:  dec.iclass = CL_NOP;
      OP_HALT: dec.iclass = CL_HALT;
      default: dec.iclass = CL_BAD;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: step-counter state register plus a Moore
// decode of state and IR that drives every datapath control input.
module control_sequencer import cpu_ctrl_pkg::*; #(
  parameter int OPW  = 5,
  parameter int REGW = 4
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [31:0]     IR,
  output logic [4:0]      BusDataSelect,
  output logic [REGW-1:0] GP_addr,
  output logic            e_PC,
  output logic            e_IR,
  output logic            e_Y,
  output logic            e_Z,
  output logic            e_HI,
  output logic            e_LO,
  output logic            e_MDR,
  output logic            e_MAR,
  output logic            e_GP,
  output logic            incPC,
  output logic            MDR_read,
  output logic [3:0]      ALU_op,
  output logic            running,
  output logic            bad_op
);

  localparam int RA_MSB = 31 - OPW;
  localparam int RB_MSB = RA_MSB - REGW;
  localparam int RC_MSB = RB_MSB - REGW;

  state_e          state_q, state_d;
  logic [REGW-1:0] ra, rb, rc;
  logic            unused_ir_low;

  assign ra = IR[RA_MSB -: REGW];
  assign rb = IR[RB_MSB -: REGW];
  assign rc = IR[RC_MSB -: REGW];
  assign unused_ir_low = ^IR[RC_MSB-REGW:0];

  control_sequencer_if #(.OPW(OPW)) dec_if ();
  assign dec_if.opcode = IR[31 -: OPW];

  control_decode u_decode (
    .dec (dec_if)
  );

  always_ff @(posedge clock) begin
    if (clear) state_q <= ST_T0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    BusDataSelect = '0;
    GP_addr       = '0;
    e_PC          = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    e_HI          = 1'b0;
    e_LO          = 1'b0;
    e_MDR         = 1'b0;
    e_MAR         = 1'b0;
    e_GP          = 1'b0;
    incPC         = 1'b0;
    MDR_read      = 1'b0;
    ALU_op        = ALU_ADD;
    running       = (state_q != ST_HALT);
    bad_op        = 1'b0;

    case (state_q)
      ST_T0: begin
        BusDataSelect = SEL_PC;
        e_MAR = 1'b1; incPC = 1'b1; e_Z = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        BusDataSelect = SEL_ZLO;
        e_PC = 1'b1; MDR_read = 1'b1; e_MDR = 1'b1;
        state_d = ST_T2;
      end
      ST_T2: begin
        BusDataSelect = SEL_MDR;
        e_IR = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        state_d = ST_T0;
        case (dec_if.iclass)
          CL_RRR: begin
            BusDataSelect = 5'(rb); e_Y = 1'b1; state_d = ST_T4;
          end
          CL_UNARY: begin
            BusDataSelect = 5'(rb); ALU_op = dec_if.alu_op; e_Z = 1'b1;
            state_d = ST_T4;
          end
          CL_MULDIV: begin
            BusDataSelect = 5'(ra); e_Y = 1'b1; state_d = ST_T4;
          end
          CL_HALT: state_d = ST_HALT;
          CL_BAD:  bad_op = 1'b1;
          default: state_d = ST_T0;
        endcase
      end
      ST_T4: begin
        state_d = ST_T0;
        case (dec_if.iclass)
          CL_RRR: begin
            BusDataSelect = 5'(rc); ALU_op = dec_if.alu_op; e_Z = 1'b1;
            state_d = ST_T5;
          end
          CL_UNARY: begin
            BusDataSelect = SEL_ZLO; GP_addr = ra; e_GP = 1'b1;
          end
          CL_MULDIV: begin
            BusDataSelect = 5'(rb); ALU_op = dec_if.alu_op; e_Z = 1'b1;
            state_d = ST_T5;
          end
          default: state_d = ST_T0;
        endcase
      end
      ST_T5: begin
        state_d = ST_T0;
        case (dec_if.iclass)
          CL_RRR: begin
            BusDataSelect = SEL_ZLO; GP_addr = ra; e_GP = 1'b1;
          end
          CL_MULDIV: begin
            BusDataSelect = SEL_ZLO; e_LO = 1'b1; state_d = ST_T6;
          end
          default: state_d = ST_T0;
        endcase
      end
      ST_T6: begin
        BusDataSelect = SEL_ZHI;
        e_HI = 1'b1;
        state_d = ST_T0;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_T0;
    endcase

    // Clear masks the whole decode in the same cycle, so an abandoned
    // instruction can never complete its write-back.
    if (clear) begin
      state_d       = ST_T0;
      BusDataSelect = '0;
      GP_addr       = '0;
      e_PC          = 1'b0;
      e_IR          = 1'b0;
      e_Y           = 1'b0;
      e_Z           = 1'b0;
      e_HI          = 1'b0;
      e_LO          = 1'b0;
      e_MDR         = 1'b0;
      e_MAR         = 1'b0;
      e_GP          = 1'b0;
      incPC         = 1'b0;
      MDR_read      = 1'b0;
      ALU_op        = '0;
      running       = 1'b0;
      bad_op        = 1'b0;
    end
  end

endmodule
